cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 122 ++++++++++++
 tb/tb_cordic_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Two-requester scheduler for a shared exp/sinh/cosh engine.
// One request in flight at a time, with round-robin arbitration on ties,
// a timeout while waiting on the engine, and a held response until it is taken.
module cordic_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_x,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_x,
    output logic        req1_ready,
    output logic [31:0] eng_x,
    output logic        eng_en,
    input  logic        eng_valid,
    input  logic [31:0] eng_epx,
    input  logic [31:0] eng_sinhx,
    input  logic [31:0] eng_coshx,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [31:0] rsp_epx,
    output logic [31:0] rsp_sinhx,
    output logic [31:0] rsp_coshx,
    output logic [15:0] done_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TIMER_W = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic                 last_grant;
    logic                 grant_id;
    logic                 accept;

    // Arbitration: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end
    end

    assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = !rst && (state == IDLE) && req1_valid &&  grant_id;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Scheduler FSM with all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            last_grant <= 1'b1;
            eng_en     <= 1'b0;
            eng_x      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_epx    <= '0;
            rsp_sinhx  <= '0;
            rsp_coshx  <= '0;
            done_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_x      <= grant_id ? req1_x : req0_x;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        eng_en     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_valid) begin
                        rsp_epx   <= eng_epx;
                        rsp_sinhx <= eng_sinhx;
                        rsp_coshx <= eng_coshx;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        eng_en    <= 1'b0;
                        state     <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        rsp_epx   <= '0;
                        rsp_sinhx <= '0;
                        rsp_coshx <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        eng_en    <= 1'b0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state     <= RESP;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized scoreboard bench for cordic_sched with an in-bench reference model.
module tb_cordic_sched;

    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_x, req1_x;
    logic        req0_ready, req1_ready;
    logic [31:0] eng_x;
    logic        eng_en;
    logic        eng_valid;
    logic [31:0] eng_epx, eng_sinhx, eng_coshx;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_epx, rsp_sinhx, rsp_coshx;
    logic [15:0] done_cnt;
    logic [7:0]  err_cnt;

    cordic_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_ready(req1_ready),
        .eng_x(eng_x), .eng_en(eng_en), .eng_valid(eng_valid),
        .eng_epx(eng_epx), .eng_sinhx(eng_sinhx), .eng_coshx(eng_coshx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_epx(rsp_epx), .rsp_sinhx(rsp_sinhx), .rsp_coshx(rsp_coshx),
        .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] ep;
        logic [31:0] sh;
        logic [31:0] ch;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    int          m_last = 1;
    logic [15:0] m_done = '0;
    int          m_err  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented response against the queue head, pop on handshake
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                chk("rsp_id",    32'(rsp_id),  32'(q[0].id));
                chk("rsp_err",   32'(rsp_err), 32'(q[0].err));
                chk("rsp_epx",   rsp_epx,      q[0].ep);
                chk("rsp_sinhx", rsp_sinhx,    q[0].sh);
                chk("rsp_coshx", rsp_coshx,    q[0].ch);
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("ready0_in_rst", 32'(req0_ready), 32'd0);
        chk("ready1_in_rst", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        m_last = 1; m_done = '0; m_err = 0;
        q.delete();
    endtask

    // One full transaction; entered one step after a rising edge with the DUT idle
    task automatic do_txn(input int p, input logic [31:0] x0, input logic [31:0] x1,
                          input int delay, input int bp,
                          input logic [31:0] ep, input logic [31:0] sh, input logic [31:0] ch,
                          input bit stray_issue);
        int          w;
        int          n;
        logic [31:0] xw;
        exp_t        e;
        req0_valid = p[0]; req1_valid = p[1];
        req0_x = x0; req1_x = x1;
        rsp_ready = 1'($urandom_range(0, 1));
        w  = (p == 1) ? 0 : (p == 2) ? 1 : (m_last == 0 ? 1 : 0);
        xw = (w == 1) ? x1 : x0;
        @(negedge clk);
        chk("ready0_grant", 32'(req0_ready), 32'(w == 0));
        chk("ready1_grant", 32'(req1_ready), 32'(w == 1));
        chk("done_cnt", 32'(done_cnt), 32'(m_done));
        chk("err_cnt",  32'(err_cnt),  32'(m_err));
        @(posedge clk); #1;
        m_last = w;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = $urandom; req1_x = $urandom;
        eng_valid = stray_issue;
        eng_epx = $urandom; eng_sinhx = $urandom; eng_coshx = $urandom;
        @(negedge clk);
        chk("issue_eng_en", 32'(eng_en), 32'd1);
        chk("issue_eng_x", eng_x, xw);
        n = (delay < TIMEOUT) ? delay : TIMEOUT;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            eng_valid = (k == delay);
            if (k == delay) begin
                eng_epx = ep; eng_sinhx = sh; eng_coshx = ch;
            end else begin
                eng_epx = $urandom; eng_sinhx = $urandom; eng_coshx = $urandom;
            end
            if (k == n) begin
                e.id  = 1'(w);
                e.err = (delay > TIMEOUT);
                e.ep  = e.err ? 32'd0 : ep;
                e.sh  = e.err ? 32'd0 : sh;
                e.ch  = e.err ? 32'd0 : ch;
                q.push_back(e);
                if (e.err && m_err < 255) m_err++;
            end
            @(negedge clk);
            chk("wait_eng_en", 32'(eng_en), 32'd1);
            chk("wait_eng_x", eng_x, xw);
            chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        eng_valid = 1'b0;
        eng_epx = $urandom; eng_sinhx = $urandom; eng_coshx = $urandom;
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            req1_valid = 1'b1; req1_x = $urandom;
            @(negedge clk);
            chk("resp_valid_bp", 32'(rsp_valid), 32'd1);
            chk("resp_eng_en", 32'(eng_en), 32'd0);
            chk("resp_ready0", 32'(req0_ready), 32'd0);
            chk("resp_ready1", 32'(req1_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req1_valid = 1'b0;
        m_done = m_done + 16'd1;
    endtask

    task automatic idle_stray();
        req0_valid = 1'b0; req1_valid = 1'b0;
        eng_valid = 1'b1; eng_epx = $urandom;
        @(negedge clk);
        chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
        chk("stray_eng_en", 32'(eng_en), 32'd0);
        @(posedge clk); #1;
        eng_valid = 1'b0;
    endtask

    // Accept a request, then reset two cycles into WAIT
    task automatic abort_in_wait();
        req0_valid = 1'b1; req0_x = $urandom;
        @(negedge clk);
        chk("abort_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        chk("abort_eng_en", 32'(eng_en), 32'd0);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_done", 32'(done_cnt), 32'd0);
        chk("abort_eng_x", eng_x, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req1_x = '0;
        eng_valid = 1'b0; eng_epx = '0; eng_sinhx = '0; eng_coshx = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_eng_en", 32'(eng_en), 32'd0);
        chk("rst_eng_x", eng_x, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_epx", rsp_epx, 32'd0);
        chk("rst_rsp_sinhx", rsp_sinhx, 32'd0);
        chk("rst_rsp_coshx", rsp_coshx, 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;

        // Single known-value request
        do_txn(1, 32'h0001_0000, $urandom, 5, 0, 32'h0002_B7E1, 32'h0001_2CD9, 32'h0001_8B07, 1'b0);

        // Tie run from reset: requester 0 wins first, then alternation
        do_reset();
        for (int i = 0; i < 4; i++)
            do_txn(3, $urandom, $urandom, 2, 0, $urandom, $urandom, $urandom, 1'b0);

        // Timeout and valid-at-timeout race
        do_txn(2, $urandom, $urandom, 99, 0, $urandom, $urandom, $urandom, 1'b0);
        do_txn(1, $urandom, $urandom, TIMEOUT, 0, $urandom, $urandom, $urandom, 1'b0);

        // Long backpressure with requester 1 waiting, then accepted immediately
        do_txn(1, $urandom, $urandom, 3, 10, $urandom, $urandom, $urandom, 1'b0);
        do_txn(2, $urandom, $urandom, 1, 0, $urandom, $urandom, $urandom, 1'b0);

        // Stray engine pulses in IDLE and ISSUE
        idle_stray();
        do_txn(1, $urandom, $urandom, 4, 0, $urandom, $urandom, $urandom, 1'b1);

        // Reset while waiting, then normal service
        abort_in_wait();
        do_txn(1, $urandom, $urandom, 3, 1, $urandom, $urandom, $urandom, 1'b0);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) idle_stray();
            do_txn($urandom_range(1, 3), $urandom, $urandom, $urandom_range(1, TIMEOUT + 3),
                   $urandom_range(0, 3), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        // Drive the timeout counter into saturation
        for (int i = 0; i < 260; i++)
            do_txn($urandom_range(1, 3), $urandom, $urandom, 99, 0, $urandom, $urandom, $urandom, 1'b0);

        @(negedge clk);
        chk("final_done", 32'(done_cnt), 32'(m_done));
        chk("final_err_sat", 32'(err_cnt), 32'(m_err));
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
